// File: rtl/cam_capture_rgb444.sv
// rtl/cam_capture_rgb444.sv - OV7670-style byte stream capture into RGB444 frame buffer writes
// Camera pins are oversampled in the clk domain; pclk rising edges are recovered from a 3-flop history.
module cam_capture_rgb444 #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_en,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [11:0]   mem_px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          line_err,
  output logic          busy
);

  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1) + 1;
  localparam logic [XW-1:0] X_MAX     = XW'(IMG_W);
  localparam logic [YW-1:0] Y_MAX     = YW'(IMG_H);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_FRAME      = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_pclk_s1, r_pclk_s2, r_pclk_s3;
  logic          r_vsync_s1, r_vsync_s2;
  logic          r_href_s1, r_href_s2;
  logic [7:0]    r_data_s1, r_data_s2;
  logic          r_vsync_prev, r_href_prev;
  logic          r_phase;
  logic [3:0]    r_red;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [AW-1:0] r_addr;
  logic          r_full;

  logic          w_pe;
  logic          w_vs_fall;
  logic          w_vs_rise;
  logic          w_line_end;
  logic          w_line_bad;
  logic          w_byte;
  logic [YW-1:0] w_y_next;
  logic [YW-1:0] w_y_final;

  assign w_pe       = r_pclk_s2 & ~r_pclk_s3;
  assign w_vs_fall  = w_pe & r_vsync_prev & ~r_vsync_s2;
  assign w_vs_rise  = w_pe & ~r_vsync_prev & r_vsync_s2;
  assign w_line_end = w_pe & ~r_href_s2 & r_href_prev;
  assign w_line_bad = r_phase | (r_x_cnt != X_MAX);
  // Bytes seen while vsync is high belong to blanking and are never paired.
  assign w_byte     = w_pe & r_href_s2 & ~r_vsync_s2;
  // Line counter saturates so a runaway frame can never alias back to IMG_H.
  assign w_y_next   = (&r_y_cnt) ? r_y_cnt : r_y_cnt + 1'b1;
  assign w_y_final  = w_line_end ? w_y_next : r_y_cnt;

  assign busy = (r_state == S_FRAME);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pclk_s1    <= 1'b0;
      r_pclk_s2    <= 1'b0;
      r_pclk_s3    <= 1'b0;
      r_vsync_s1   <= 1'b0;
      r_vsync_s2   <= 1'b0;
      r_href_s1    <= 1'b0;
      r_href_s2    <= 1'b0;
      r_data_s1    <= '0;
      r_data_s2    <= '0;
      r_vsync_prev <= 1'b0;
      r_href_prev  <= 1'b0;
      r_phase      <= 1'b0;
      r_red        <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_addr       <= '0;
      r_full       <= 1'b0;
      mem_px_addr  <= '0;
      mem_px_data  <= '0;
      px_wr        <= 1'b0;
      frame_done   <= 1'b0;
      line_err     <= 1'b0;
    end else begin
      r_pclk_s1  <= CAM_pclk;
      r_pclk_s2  <= r_pclk_s1;
      r_pclk_s3  <= r_pclk_s2;
      r_vsync_s1 <= CAM_vsync;
      r_vsync_s2 <= r_vsync_s1;
      r_href_s1  <= CAM_href;
      r_href_s2  <= r_href_s1;
      r_data_s1  <= CAM_px_data;
      r_data_s2  <= r_data_s1;

      px_wr      <= 1'b0;
      frame_done <= 1'b0;

      if (w_pe) begin
        r_vsync_prev <= r_vsync_s2;
        r_href_prev  <= r_href_s2;
      end

      case (r_state)
        S_IDLE: begin
          if (capture_en) r_state <= S_WAIT_FRAME;
        end

        S_WAIT_FRAME: begin
          if (!capture_en) begin
            r_state <= S_IDLE;
          end else if (w_vs_fall) begin
            r_state  <= S_FRAME;
            r_addr   <= '0;
            r_full   <= 1'b0;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_phase  <= 1'b0;
            line_err <= 1'b0;
          end
        end

        S_FRAME: begin
          if (w_line_end) begin
            if (w_line_bad) line_err <= 1'b1;
            r_x_cnt <= '0;
            r_phase <= 1'b0;
            r_y_cnt <= w_y_next;
          end

          if (w_byte) begin
            if (!r_phase) begin
              r_red   <= r_data_s2[3:0];
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (r_full || (r_x_cnt == X_MAX)) begin
                line_err <= 1'b1;
              end else begin
                px_wr       <= 1'b1;
                mem_px_addr <= r_addr;
                mem_px_data <= {r_red, r_data_s2};
                r_x_cnt     <= r_x_cnt + 1'b1;
                // Park on the last address instead of wrapping; r_full blocks further writes.
                if (r_addr == LAST_ADDR) r_full <= 1'b1;
                else                     r_addr <= r_addr + 1'b1;
              end
            end
          end

          if (w_vs_rise) begin
            frame_done <= 1'b1;
            if (w_y_final != Y_MAX) line_err <= 1'b1;
            r_state <= capture_en ? S_WAIT_FRAME : S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// tb/tb_cam_capture_rgb444.sv - randomized frame stimulus against a line/pixel-level capture model
module tb_cam_capture_rgb444;
  localparam int IMG_W = 16;
  localparam int IMG_H = 6;
  localparam int AW    = 15;
  localparam int NPIX  = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          capture_en = 1'b0;
  logic          CAM_pclk = 1'b0;
  logic          CAM_vsync = 1'b0;
  logic          CAM_href = 1'b0;
  logic [7:0]    CAM_px_data = '0;
  logic [AW-1:0] mem_px_addr;
  logic [11:0]   mem_px_data;
  logic          px_wr;
  logic          frame_done;
  logic          line_err;
  logic          busy;

  cam_capture_rgb444 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .capture_en  (capture_en),
    .CAM_pclk    (CAM_pclk),
    .CAM_vsync   (CAM_vsync),
    .CAM_href    (CAM_href),
    .CAM_px_data (CAM_px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .frame_done  (frame_done),
    .line_err    (line_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int act_done = 0;
  logic [AW+11:0] exp_q[$];
  bit             err_q[$];
  logic [AW+11:0] mon_e;
  logic [7:0]     fb[0:15][0:63];
  int             flen[0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every write and every frame_done is matched against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      if (px_wr) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr: got addr %0d data %03h expected no write at %0t", mem_px_addr, mem_px_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(mem_px_addr), 32'(mon_e[AW+11:12]));
          chk("wr_data", 32'(mem_px_data), 32'(mon_e[11:0]));
        end
      end
      if (frame_done) begin
        act_done++;
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_done: got pulse expected none at %0t", $time);
        end else begin
          chk("frame_line_err", 32'(line_err), 32'(err_q.pop_front()));
        end
      end
    end
  end

  task automatic pclk_cycle(input bit v, input bit h, input logic [7:0] d);
    @(negedge clk); CAM_pclk = 1'b0; CAM_vsync = v; CAM_href = h; CAM_px_data = d;
    @(negedge clk);
    @(negedge clk); CAM_pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_nominal(input int nl);
    for (int l = 0; l < nl; l++) begin
      flen[l] = 2 * IMG_W;
      for (int b = 0; b < 64; b++)
        fb[l][b] = (b % 8 == 1 || b % 8 == 3) ? 8'h0F : (b % 8 == 5 || b % 8 == 7) ? 8'hF0 : 8'h00;
    end
  endtask

  task automatic fill_random(input int nl);
    for (int l = 0; l < nl; l++) begin
      flen[l] = 2 * IMG_W;
      for (int b = 0; b < 64; b++) fb[l][b] = 8'($urandom);
    end
  endtask

  // Model: bytes pair up per line; a pair becomes a write unless the line already holds IMG_W
  // pixels or the frame already holds NPIX. stop_line >= 0 cuts the frame before byte stop_byte.
  task automatic model_frame(input int nl, input int stop_line, input int stop_byte);
    int addr, wr;
    bit err;
    addr = 0; err = 0;
    for (int l = 0; l < nl; l++) begin
      wr = 0;
      for (int b = 0; b + 1 < flen[l]; b += 2) begin
        if (l == stop_line && b + 1 >= stop_byte) break;
        if (wr == IMG_W || addr >= NPIX) err = 1;
        else begin
          exp_q.push_back({addr[AW-1:0], fb[l][b][3:0], fb[l][b+1]});
          addr++; wr++;
        end
      end
      if (l == stop_line) return;
      if ((flen[l] % 2) != 0 || wr != IMG_W) err = 1;
    end
    if (nl != IMG_H) err = 1;
    err_q.push_back(err);
    exp_done++;
  endtask

  task automatic do_reset();
    repeat (8) @(negedge clk);
    chk("pre_reset_drain", 32'(exp_q.size()), 32'd0);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_px_wr", 32'(px_wr), 32'd0);
    chk("async_rst_addr", 32'(mem_px_addr), 32'd0);
    chk("async_rst_data", 32'(mem_px_data), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic send_frame(input int nl, input int en_line, input bit en_val,
                            input int rst_line, input int rst_byte);
    for (int i = 0; i < 4; i++) pclk_cycle(1'b1, (i == 1 || i == 2), 8'($urandom));
    pclk_cycle(1'b0, 1'b0, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    for (int l = 0; l < nl; l++) begin
      for (int b = 0; b < flen[l]; b++) begin
        if (l == en_line && b == 4) capture_en = en_val;
        if (l == rst_line && b == rst_byte) do_reset();
        pclk_cycle(1'b0, 1'b1, fb[l][b]);
      end
      for (int g = 0; g < 3; g++) pclk_cycle(1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, pick;

    for (int i = 0; i < 6; i++) begin
      pclk_cycle(i[0], 1'b1, 8'($urandom));
      chk("rst_px_wr", 32'(px_wr), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_line_err", 32'(line_err), 32'd0);
      chk("rst_addr", 32'(mem_px_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    CAM_vsync = 1'b0; CAM_href = 1'b0;
    @(negedge clk); rst = 1'b1; capture_en = 1'b1;

    fill_nominal(IMG_H);
    model_frame(IMG_H, -1, 0);
    chk("model_nominal_count", 32'(exp_q.size()), 32'd96);
    chk("model_px0", 32'(exp_q[0][11:0]), 32'h00F);
    chk("model_px1", 32'(exp_q[1][11:0]), 32'h00F);
    chk("model_px2", 32'(exp_q[2][11:0]), 32'h0F0);
    chk("model_last_addr", 32'(exp_q[95][AW+11:12]), 32'd95);
    send_frame(IMG_H, -1, 1'b1, -1, 0);

    fill_random(IMG_H);
    flen[2] = 2 * IMG_W - 1;
    model_frame(IMG_H, -1, 0);
    chk("model_short_count", 32'(exp_q.size()), 32'd95);
    chk("model_short_err", 32'(err_q[err_q.size()-1]), 32'd1);
    chk("model_short_next_line_addr", 32'(exp_q[47][AW+11:12]), 32'd47);
    send_frame(IMG_H, -1, 1'b1, -1, 0);

    fill_random(IMG_H);
    model_frame(IMG_H, -1, 0);
    chk("model_clean_err", 32'(err_q[err_q.size()-1]), 32'd0);
    send_frame(IMG_H, -1, 1'b1, -1, 0);

    fill_random(IMG_H + 1);
    model_frame(IMG_H + 1, -1, 0);
    chk("model_ovf_count", 32'(exp_q.size()), 32'd96);
    chk("model_ovf_err", 32'(err_q[err_q.size()-1]), 32'd1);
    send_frame(IMG_H + 1, -1, 1'b1, -1, 0);

    fill_random(IMG_H);
    model_frame(IMG_H, -1, 0);
    send_frame(IMG_H, 3, 1'b0, -1, 0);

    fill_random(IMG_H);
    send_frame(IMG_H, 2, 1'b1, -1, 0);

    fill_nominal(IMG_H);
    model_frame(IMG_H, -1, 0);
    send_frame(IMG_H, -1, 1'b1, -1, 0);

    fill_random(IMG_H);
    model_frame(IMG_H, 2, 10);
    chk("model_partial_count", 32'(exp_q.size()), 32'd37);
    send_frame(IMG_H, -1, 1'b1, 2, 10);

    fill_nominal(IMG_H);
    model_frame(IMG_H, -1, 0);
    send_frame(IMG_H, -1, 1'b1, -1, 0);

    for (int f = 0; f < 6; f++) begin
      nl = IMG_H + int'($urandom_range(0, 2)) - 1;
      fill_random(nl);
      for (int l = 0; l < nl; l++) begin
        pick = int'($urandom_range(0, 7));
        flen[l] = (pick == 5) ? 2 * IMG_W - 1 : (pick == 6) ? 2 * IMG_W - 2 :
                  (pick == 7) ? 2 * IMG_W + 2 : 2 * IMG_W;
      end
      model_frame(nl, -1, 0);
      send_frame(nl, -1, 1'b1, -1, 0);
    end

    for (int i = 0; i < 4; i++) pclk_cycle(1'b1, 1'b0, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    repeat (20) @(negedge clk);
    chk("exp_writes_drained", 32'(exp_q.size()), 32'd0);
    chk("exp_frames_drained", 32'(err_q.size()), 32'd0);
    chk("frame_done_count", 32'(act_done), 32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
